// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART transmit path.
//                Provides the arbiter FSM state encoding, the default byte
//                width and the 115200-baud divider for a 10 MHz clock.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int CLK_CYCLES_115200 = 87;

    // Arbiter FSM encoding, fixed 2-bit width.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Request and transceiver-handshake bundle for uart_tx_arbiter.
//  Ports (signals):
//    in_req    [N]         per-requester level request
//    in_data   [N*DATA_W]  requester i byte at in_data[i*DATA_W +: DATA_W]
//    in_ack    [N]         one-cycle "byte taken" pulse
//    in_lock   [N]         hold-grant request (only with UART_ARB_LOCK_EN)
//    tx_data   [DATA_W]    byte to the transceiver
//    tx_req                one-cycle start pulse to the transceiver
//    tx_ready              transceiver idle (1) / busy (0)
//    busy                  arbiter not in IDLE
//    grant_idx [IDX_W]     last granted requester
//  Modports    : master = arbiter side, slave = requesters + transceiver.
//  Options     : UART_ARB_LOCK_EN adds in_lock.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]        in_req;
    logic [N*DATA_W-1:0] in_data;
    logic [N-1:0]        in_ack;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_req;
    logic                tx_ready;
    logic                busy;
    logic [IDX_W-1:0]    grant_idx;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]        in_lock;

    modport master (
        input  in_req, in_data, in_lock, tx_ready,
        output in_ack, tx_data, tx_req, busy, grant_idx
    );
    modport slave (
        output in_req, in_data, in_lock, tx_ready,
        input  in_ack, tx_data, tx_req, busy, grant_idx
    );
`else
    modport master (
        input  in_req, in_data, tx_ready,
        output in_ack, tx_data, tx_req, busy, grant_idx
    );
    modport slave (
        output in_req, in_data, tx_ready,
        input  in_ack, tx_data, tx_req, busy, grant_idx
    );
`endif

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Returns the first asserted
//                request scanning ptr+1, ptr+2, ... modulo N.
//  Ports       : req [N] requests, ptr [IDX_W] last winner,
//                valid  any request asserted, idx [IDX_W] winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic                  valid,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the farthest offset down to the nearest so the nearest
    // asserted requester after ptr overwrites any earlier candidate.
    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int off = N; off >= 1; off--) begin
            j = (int'(ptr) + off) % N;
            if (req[IDX_W'(j)]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmit channel between N byte sources with
//                round-robin arbitration. Issues a one-cycle tx_req with the
//                winning byte and a one-cycle in_ack to the winner, then waits
//                for the transceiver to go busy and idle again.
//  Ports       : clk, rst (async, active-high)
//                bus (uart_tx_arbiter_if.master) - requests and handshake
//  Options     : UART_ARB_LOCK_EN - a locked, still-requesting last winner is
//                granted again without advancing the round-robin pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int N      = 4,
    parameter  int DATA_W = UART_DATA_W,
    localparam int IDX_W  = $clog2(N)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    uart_tx_arbiter_if.master   bus
);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              tx_req_q, tx_req_d;
    logic              busy_q, busy_d;

    logic              w_pick_valid;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_lock_hit;

    rr_pick #(.N(N)) u_rr_pick (
        .req   (bus.in_req),
        .ptr   (ptr_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

`ifdef UART_ARB_LOCK_EN
    assign w_lock_hit = bus.in_lock[grant_q] && bus.in_req[grant_q];
`else
    assign w_lock_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= IDX_W'(N - 1);
            grant_q  <= IDX_W'(N - 1);
            data_q   <= '0;
            ack_q    <= '0;
            tx_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            tx_req_q <= tx_req_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        logic [IDX_W-1:0] g;
        g        = grant_q;
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        ack_d    = '0;
        tx_req_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_ready && (w_lock_hit || w_pick_valid)) begin
                    g        = w_lock_hit ? grant_q : w_pick_idx;
                    data_d   = bus.in_data[g*DATA_W +: DATA_W];
                    ack_d[g] = 1'b1;
                    tx_req_d = 1'b1;
                    grant_d  = g;
                    // A locked re-grant leaves the rotation where it was.
                    ptr_d    = w_lock_hit ? ptr_q : g;
                    state_d  = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.tx_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (bus.tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.tx_data   = data_q;
    assign bus.tx_req    = tx_req_q;
    assign bus.in_ack    = ack_q;
    assign bus.busy      = busy_q;
    assign bus.grant_idx = grant_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter (N=4).
//                Drives tx_ready by hand in place of a transceiver.
//  Options     : UART_ARB_LOCK_EN enables the lock scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N      = 4;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.N(N), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a tx_req pulse and check the grant it carries.
    task automatic wait_grant(input string tag, input int exp_idx, input logic [7:0] exp_data);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.tx_req) seen = 1'b1;
        end
        check({tag, " tx_req"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " grant_idx"}, 32'(bus.grant_idx), 32'(exp_idx));
            check({tag, " tx_data"},   32'(bus.tx_data),   32'(exp_data));
            check({tag, " in_ack"},    32'(bus.in_ack),    32'(1) << exp_idx);
            check({tag, " busy"},      32'(bus.busy),      32'd1);
        end
    endtask

    // Transceiver goes busy for one cycle then idle; arbiter ends in IDLE.
    task automatic finish_xfer(input string tag);
        @(negedge clk);
        bus.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " pulse ends"}, {30'd0, bus.tx_req, |bus.in_ack}, 32'd0);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " idle busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.in_req   = '0;
        bus.in_data  = '0;
        bus.tx_ready = 1'b1;
`ifdef UART_ARB_LOCK_EN
        bus.in_lock  = '0;
`endif
        #12;
        check("rst tx_req",    32'(bus.tx_req),    32'd0);
        check("rst in_ack",    32'(bus.in_ack),    32'd0);
        check("rst busy",      32'(bus.busy),      32'd0);
        check("rst grant_idx", 32'(bus.grant_idx), 32'd3);
        check("rst tx_data",   32'(bus.tx_data),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single source
        bus.in_data = {8'h00, 8'h00, 8'h00, 8'h41};
        bus.in_req  = 4'b0001;
        wait_grant("single", 0, 8'h41);
        bus.in_req = 4'b0000;
        finish_xfer("single");

        // Round-robin with all four held
        do_reset();
        bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.in_req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("rr%0d", i), i % 4, 8'(8'h10 + (i % 4)));
            if (i == 4) bus.in_req = 4'b0000;
            finish_xfer($sformatf("rr%0d", i));
        end

        // Late request while in WAIT_HIGH with ptr=2
        do_reset();
        bus.in_req = 4'b0100;
        wait_grant("ptr2", 2, 8'h12);
        bus.in_req = 4'b0000;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("wait_high busy", 32'(bus.busy), 32'd1);
        bus.in_req = 4'b1001;
        cnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.tx_req) cnt++;
        end
        check("wait_high no req", 32'(cnt), 32'd0);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        wait_grant("late", 3, 8'h13);
        bus.in_req = 4'b0001;
        finish_xfer("late");
        wait_grant("late next", 0, 8'h10);
        bus.in_req = 4'b0000;
        finish_xfer("late next");

        // Backpressure for 50 cycles; ptr=0 so requester 1 wins
        @(negedge clk);
        bus.tx_ready = 1'b0;
        bus.in_req   = 4'b0010;
        cnt = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (bus.tx_req || (|bus.in_ack)) cnt++;
        end
        check("bp no pulse", 32'(cnt), 32'd0);
        check("bp busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp tx_req", 32'(bus.tx_req), 32'd1);
        check("bp in_ack", 32'(bus.in_ack), 32'h2);
        check("bp tx_data", 32'(bus.tx_data), 32'h11);

        // Async reset while in WAIT_LOW, transceiver still busy
        #2;
        bus.tx_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid rst tx_req",    32'(bus.tx_req),    32'd0);
        check("mid rst in_ack",    32'(bus.in_ack),    32'd0);
        check("mid rst busy",      32'(bus.busy),      32'd0);
        check("mid rst grant_idx", 32'(bus.grant_idx), 32'd3);
        check("mid rst tx_data",   32'(bus.tx_data),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.tx_req) cnt++;
        end
        check("post rst held", 32'(cnt), 32'd0);
        @(negedge clk);
        bus.tx_ready = 1'b1;
        wait_grant("post rst", 1, 8'h11);
        bus.in_req = 4'b0000;
        finish_xfer("post rst");

`ifdef UART_ARB_LOCK_EN
        // Locked requester 0 keeps the channel for three bytes
        do_reset();
        bus.in_lock = 4'b0001;
        bus.in_req  = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            wait_grant($sformatf("lock%0d", i), 0, 8'h10);
            if (i == 2) bus.in_lock = 4'b0000;
            finish_xfer($sformatf("lock%0d", i));
        end
        wait_grant("unlock", 1, 8'h11);
        bus.in_req = 4'b0000;
        finish_xfer("unlock");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tranceiver transmit channel between N independent byte sources, such as a button-event reporter, a counter dump and a debug echo.
- Arbitrates round-robin among asserted requests.
- Drives the transceiver's data/req/ready handshake and returns a one-cycle ack to the winning requester.
- Sits between the requesting logic in fpga and the uart_tranceiver instance (clk domain, 10 MHz).

Parameters:
- N, 4, number of requesters (2..8).
- DATA_W, 8, byte width per requester.
- IDX_W, $clog2(N), localparam, width of the grant index.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- in_req  input  N  per-requester level request; held until the matching ack.
- in_data  input  N*DATA_W  requester i's byte is in_data[i*DATA_W +: DATA_W]; must be stable while in_req[i] is high.
- in_ack  output  N  one-cycle pulse: requester i's byte has been taken.
- tx_data  output  DATA_W  byte to the transceiver; registered.
- tx_req  output  1  one-cycle start pulse to the transceiver.
- tx_ready  input  1  transceiver idle (high) / busy (low).
- busy  output  1  high in any state other than IDLE.
- grant_idx  output  IDX_W  index of the last granted requester.
- in_lock  input  N  only present with UART_ARB_LOCK_EN.

Behaviour:
- Reset (async assert, sync release) drives:
  - tx_req=0, tx_data=0, in_ack=0, busy=0, grant_idx=N-1.
  - state=IDLE; round-robin pointer ptr=N-1, so requester 0 wins first.
- All outputs are registered.
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH.
- IDLE: at edge k, if tx_ready=1 and |in_req:
  - Winner g = first asserted index scanning ptr+1, ptr+2, ... modulo N.
  - At k+1: tx_data=in_data[g], tx_req=1, in_ack[g]=1, grant_idx=g, ptr=g, busy=1, state=WAIT_LOW.
  - Request-to-tx_req latency is exactly 1 cycle.
- IDLE with tx_ready=0 or no requests: hold; no pulses.
- WAIT_LOW: tx_req and in_ack return to 0 after one cycle. Stay until tx_ready=0, then go to WAIT_HIGH.
- WAIT_HIGH: stay until tx_ready=1, then go to IDLE with busy=0.
- Minimum issue spacing is 4 cycles; the next grant is decided in the IDLE cycle.
- tx_data holds its value until the next grant.
- Only one in_ack bit is ever high; in_ack never fires without tx_req.
- A request dropped before the decision edge is ignored; requests seen in the decision cycle only matter through that cycle's sample.
- A request raised while busy waits. Fairness: with all N requests held, each is served once every N grants.
- The ptr wrap from N-1 to 0 is modulo N; for non-power-of-two N, ptr never exceeds N-1.
- Reset mid-transfer: the FSM returns to IDLE immediately and the pending ack is lost.
  - The transceiver is not reset by this block.
  - No new tx_req is issued until tx_ready is sampled high.

Optional Feature:
- UART_ARB_LOCK_EN defined:
  - Adds the in_lock port.
  - On returning to IDLE, if in_lock[grant_idx] and in_req[grant_idx] are both high, that requester is granted again regardless of the round-robin order, and ptr is unchanged. This lets multi-byte messages go out unbroken.
- UART_ARB_LOCK_EN not defined: the port is absent and arbitration is pure round-robin.

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams IDLE=2'd0, WAIT_LOW=2'd1, WAIT_HIGH=2'd2.
  - UART_DATA_W=8.
  - Baud constant CLK_CYCLES_115200=87.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N], ptr[IDX_W].
  - Outputs: valid, idx[IDX_W].
  - Instanced once.

Test Plan:
- Single source: in_req=4'b0001, in_data[0]=8'h41, tx_ready=1 → tx_req and in_ack=4'b0001 one cycle later, tx_data=8'h41, busy=1. After the model drops and then restores ready, busy=0.
- Round-robin: in_req=4'b1111 held with bytes 0x10..0x13 → grant order 0,1,2,3,0; tx_data sequence 10,11,12,13,10.
- Late request during WAIT_HIGH with ptr=2: in_req=4'b1001 → requester 3 wins before requester 0.
- Backpressure: tx_ready=0 with in_req=4'b0010 for 50 cycles → no tx_req, no ack. Ready rises at cycle t → tx_req at t+1.
- Reset: assert rst in WAIT_LOW → outputs zero asynchronously, grant_idx=N-1. With tx_ready low, no request is issued until ready is high.
- UART_ARB_LOCK_EN: in_req=4'b0011, in_lock[0]=1 → requester 0 is granted three times. When in_lock[0] drops, requester 1 is granted next.
